// File: rtl/pdm_sample_deserializer.sv
// PDM microphone front end: drives mic_clk, samples the 1-bit stream and
// assembles DATA_W-bit words. Optional macro DESER_DENSITY_EN: ones-density mode.
module pdm_sample_deserializer #(
    parameter int MCLK_HALF_DIV = 25,
    parameter int DATA_W        = 16,
    parameter bit LR_CHANNEL    = 1'b0,
    parameter int WIN_LOG2      = 6
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              mic_data,
    output logic              mic_clk,
    output logic              lr_sel,
    output logic [DATA_W-1:0] data_out,
    output logic              done,
    output logic              busy
);

`ifdef DESER_DENSITY_EN
    localparam int N_SAMP = 2 ** WIN_LOG2;
`else
    localparam int N_SAMP = DATA_W;
`endif
    localparam int DIV_W = $clog2(MCLK_HALF_DIV);
    localparam int CNT_W = $clog2(N_SAMP);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(MCLK_HALF_DIV - 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(N_SAMP - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state;
    logic [DIV_W-1:0]   div;
    logic [CNT_W-1:0]   bitcnt;
    logic               sample_edge;
    logic               word_end;
    logic [DATA_W-1:0]  word_val;

`ifdef DESER_DENSITY_EN
    logic [WIN_LOG2:0]   ones;
    logic [WIN_LOG2:0]   total;
    logic [WIN_LOG2-1:0] sat;
`else
    logic [DATA_W-1:0]   shift;
    logic [DATA_W-1:0]   shifted;
`endif

    assign lr_sel = LR_CHANNEL;

    // Sample point is the last cycle of the mic_clk high phase
    always_comb begin
        sample_edge = (div == DIV_LAST) && mic_clk;
        word_end    = sample_edge && (bitcnt == BIT_LAST);
`ifdef DESER_DENSITY_EN
        total    = ones + {{WIN_LOG2{1'b0}}, mic_data};
        sat      = total[WIN_LOG2] ? {WIN_LOG2{1'b1}} : total[WIN_LOG2-1:0];
        word_val = DATA_W'(sat) << (DATA_W - WIN_LOG2);
`else
        shifted  = {shift[DATA_W-2:0], mic_data};
        word_val = shifted;
`endif
    end

    // Control FSM, clock divider, sample accumulator and output word register
    always_ff @(posedge clock) begin
        done <= 1'b0;
        if (reset) begin
            state    <= IDLE;
            mic_clk  <= 1'b0;
            div      <= '0;
            bitcnt   <= '0;
            data_out <= '0;
            busy     <= 1'b0;
`ifdef DESER_DENSITY_EN
            ones     <= '0;
`else
            shift    <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    mic_clk <= 1'b0;
                    div     <= '0;
                    bitcnt  <= '0;
`ifdef DESER_DENSITY_EN
                    ones    <= '0;
`else
                    shift   <= '0;
`endif
                    if (enable) begin
                        state <= RUN;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    // A word finishing on the same edge enable drops still completes
                    if (word_end) begin
                        data_out <= word_val;
                        done     <= 1'b1;
                    end
                    if (!enable) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        mic_clk <= 1'b0;
                        div     <= '0;
                        bitcnt  <= '0;
`ifdef DESER_DENSITY_EN
                        ones    <= '0;
`else
                        shift   <= '0;
`endif
                    end else begin
                        if (div == DIV_LAST) begin
                            div     <= '0;
                            mic_clk <= ~mic_clk;
                        end else begin
                            div <= div + 1'b1;
                        end
                        if (sample_edge) begin
                            bitcnt <= word_end ? '0 : bitcnt + 1'b1;
`ifdef DESER_DENSITY_EN
                            ones   <= word_end ? '0 : total;
`else
                            shift  <= shifted;
`endif
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
